decoder3x8_seq: RTL and testbench

Sequenced 3-to-8 one-hot decoder: the output-side counterpart of the team's 8x3 one-hot encoder. It accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot line on `out_data` for a programmable number of cycles. It buffers one pending code so that successive codes can be driven back-to-back. It sits between a code-producing controller and one-hot consumers such as LED banks, chip-selects or mux selects.

---
 rtl/decoder3x8_pkg.sv | 13 +
 rtl/decoder3x8_core.sv | 16 +
 rtl/decoder3x8_seq.sv | 137 +++++++++++++
 tb/tb_decoder3x8_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decoder3x8_pkg.sv
// rtl/decoder3x8_pkg.sv - shared constants and state type for the sequenced 3-to-8 decoder
package decoder3x8_pkg;

  localparam int CODE_W   = 3;
  localparam int LINES    = 8;
  localparam int HITCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } dec_state_t;

endpackage

// File: rtl/decoder3x8_core.sv
// rtl/decoder3x8_core.sv - combinational code-to-one-hot map, all zeros when disabled
module decoder3x8_core
  import decoder3x8_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [LINES-1:0]  onehot
);

  // One line per code; disabled means no line at all
  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder3x8_seq.sv
// rtl/decoder3x8_seq.sv - sequenced one-hot decoder with one-entry pending buffer; optional hit counters via DECODER3X8_HITCNT_EN
module decoder3x8_seq
  import decoder3x8_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic [HOLD_W-1:0]   in_hold,
  output logic [LINES-1:0]    out_data,
  output logic                out_valid,
  output logic                busy,
  input  logic [CODE_W-1:0]   hit_sel,
  output logic [HITCNT_W-1:0] hit_cnt
);

  localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

  dec_state_t         state_q, state_d;
  logic [CODE_W-1:0]  cur_code_q, cur_code_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [CODE_W-1:0]  pend_code_q, pend_code_d;
  logic [HOLD_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic               xfer;
  logic               ld_en;
  logic [CODE_W-1:0]  ld_code;

  // cnt holds remaining cycles after the current one, so a hold of 0 or 1 both mean cnt = 0
  function automatic logic [HOLD_W-1:0] hold_to_cnt(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : (h - CNT_ONE);
  endfunction

  assign in_ready = !pend_valid_q;
  assign xfer     = in_valid && !pend_valid_q;
  assign busy     = (state_q == DRIVE) || pend_valid_q;

  // Next-state: load from idle, count down, and on the last cycle pick pending > bypass > idle
  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_cnt_d   = pend_cnt_q;
    ld_en        = 1'b0;
    ld_code      = cur_code_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = DRIVE;
          cur_code_d = in_code;
          cnt_d      = hold_to_cnt(in_hold);
          ld_en      = 1'b1;
          ld_code    = in_code;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_code_d  = in_code;
            pend_cnt_d   = hold_to_cnt(in_hold);
          end
        end else if (pend_valid_q) begin
          cur_code_d   = pend_code_q;
          cnt_d        = pend_cnt_q;
          pend_valid_d = 1'b0;
          ld_en        = 1'b1;
          ld_code      = pend_code_q;
        end else if (xfer) begin
          cur_code_d = in_code;
          cnt_d      = hold_to_cnt(in_hold);
          ld_en      = 1'b1;
          ld_code    = in_code;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any code being driven and any pending code
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_code_q   <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_cnt_q   <= pend_cnt_d;
    end
  end

  decoder3x8_core u_core (
    .code   (cur_code_q),
    .en     (state_q == DRIVE),
    .onehot (out_data)
  );

  assign out_valid = |out_data;

`ifdef DECODER3X8_HITCNT_EN
  localparam logic [HITCNT_W-1:0] HIT_ONE = {{(HITCNT_W-1){1'b0}}, 1'b1};

  logic [HITCNT_W-1:0] hit_q [LINES];

  // Saturating per-line count of codes loaded into DRIVE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) hit_q[i] <= '0;
    end else if (ld_en && (hit_q[ld_code] != '1)) begin
      hit_q[ld_code] <= hit_q[ld_code] + HIT_ONE;
    end
  end

  assign hit_cnt = hit_q[hit_sel];
`else
  logic unused_hit;

  assign hit_cnt    = '0;
  assign unused_hit = ^{hit_sel, ld_en, ld_code};
`endif

endmodule

// File: tb/tb_decoder3x8_seq.sv
// tb/tb_decoder3x8_seq.sv - self-checking bench for decoder3x8_seq (honours DECODER3X8_HITCNT_EN)
module tb_decoder3x8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [3:0] in_hold;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic [2:0] hit_sel;
  logic [7:0] hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] code;
    logic [3:0] hold;
    logic [7:0] exp_data;
    int         exp_len;
  } vec_t;

  vec_t vecs [8];

  decoder3x8_seq #(.HOLD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_hold   (in_hold),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .hit_sel   (hit_sel),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] b2b_data [6];
    logic       b2b_rdy  [6];
    logic       saw_code2;

    vecs[0] = '{code: 3'd3, hold: 4'd3,  exp_data: 8'h08, exp_len: 3};
    vecs[1] = '{code: 3'd7, hold: 4'd0,  exp_data: 8'h80, exp_len: 1};
    vecs[2] = '{code: 3'd0, hold: 4'd1,  exp_data: 8'h01, exp_len: 1};
    vecs[3] = '{code: 3'd5, hold: 4'd15, exp_data: 8'h20, exp_len: 15};
    vecs[4] = '{code: 3'd2, hold: 4'd2,  exp_data: 8'h04, exp_len: 2};
    vecs[5] = '{code: 3'd6, hold: 4'd4,  exp_data: 8'h40, exp_len: 4};
    vecs[6] = '{code: 3'd1, hold: 4'd1,  exp_data: 8'h02, exp_len: 1};
    vecs[7] = '{code: 3'd4, hold: 4'd8,  exp_data: 8'h10, exp_len: 8};

    b2b_data = '{8'h02, 8'h02, 8'h02, 8'h40, 8'h40, 8'h00};
    b2b_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    in_hold  = '0;
    hit_sel  = '0;
    step();
    step();
    check("reset out_data", out_data, 8'h00);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset hit_cnt", hit_cnt, 8'h00);
    rst = 1'b0;
    step();

    // Single codes from idle, including hold 0 and the maximum hold
    foreach (vecs[v]) begin
      in_valid = 1'b1;
      in_code  = vecs[v].code;
      in_hold  = vecs[v].hold;
      check($sformatf("v%0d in_ready idle", v), in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < vecs[v].exp_len; c++) begin
        check($sformatf("v%0d out_data c%0d", v, c), out_data, vecs[v].exp_data);
        check($sformatf("v%0d out_valid c%0d", v, c), out_valid, 1'b1);
        step();
      end
      check($sformatf("v%0d out_data end", v), out_data, 8'h00);
      check($sformatf("v%0d out_valid end", v), out_valid, 1'b0);
      check($sformatf("v%0d busy end", v), busy, 1'b0);
    end

    // Back-to-back through the pending buffer: code 1 hold 4, then code 6 hold 2
    in_valid = 1'b1;
    in_code  = 3'd1;
    in_hold  = 4'd4;
    step();
    check("b2b first cycle", out_data, 8'h02);
    in_code = 3'd6;
    in_hold = 4'd2;
    for (int i = 0; i < 6; i++) begin
      step();
      in_valid = 1'b0;
      check($sformatf("b2b out_data %0d", i), out_data, b2b_data[i]);
      check($sformatf("b2b in_ready %0d", i), in_ready, b2b_rdy[i]);
    end

    // Streaming with bypass: one new line per cycle, buffer never fills
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i);
      in_hold  = 4'd1;
      step();
      check($sformatf("stream out_data %0d", i), out_data, 8'h01 << i);
      check($sformatf("stream in_ready %0d", i), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream drained", out_data, 8'h00);

    // Reset mid-DRIVE with a code pending
    in_valid = 1'b1;
    in_code  = 3'd5;
    in_hold  = 4'd10;
    step();
    in_code = 3'd2;
    in_hold = 4'd3;
    step();
    in_valid = 1'b0;
    check("rstmid pending in_ready", in_ready, 1'b0);
    check("rstmid busy", busy, 1'b1);
    step();
    step();
    check("rstmid cycle4 out_data", out_data, 8'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hit_sel = 3'd5;
    check("rstmid out_data", out_data, 8'h00);
    check("rstmid busy after", busy, 1'b0);
    check("rstmid in_ready after", in_ready, 1'b1);
    check("rstmid hit_cnt cleared", hit_cnt, 8'h00);
    saw_code2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_data != 8'h00) saw_code2 = 1'b1;
    end
    check("rstmid no later output", saw_code2, 1'b0);

    // Hit counters: 300 loads of code 4
    hit_sel  = 3'd4;
    in_valid = 1'b1;
    in_code  = 3'd4;
    in_hold  = 4'd1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 99) begin
`ifdef DECODER3X8_HITCNT_EN
        check("hit_cnt line4 after 100", hit_cnt, 8'd100);
`else
        check("hit_cnt tied 0 after 100", hit_cnt, 8'd0);
`endif
      end
    end
    in_valid = 1'b0;
    step();
    step();
`ifdef DECODER3X8_HITCNT_EN
    check("hit_cnt line4 saturated", hit_cnt, 8'd255);
`else
    check("hit_cnt line4 tied 0", hit_cnt, 8'd0);
`endif
    hit_sel = 3'd0;
    #1;
    check("hit_cnt line0", hit_cnt, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
